regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every register and port.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width; NREGS = 2**ADDR_W; top address (NREGS-1) is the PC alias.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports we0, we1  input  1 each  write enables, ports 0 and 1.
REQ-006 SHALL have ports wa0, wa1  input  ADDR_W each  write addresses.
REQ-007 SHALL have ports wd0, wd1  input  WIDTH each  write data.
REQ-008 SHALL have ports ra0, ra1, ra2  input  ADDR_W each  read addresses.
REQ-009 SHALL have port pc_in  input  WIDTH  value returned for reads of the PC alias (PC+8).
REQ-010 SHALL have ports rd0, rd1, rd2  output  WIDTH each  read data.
REQ-011 SHALL have port ready  output  1  high when clear sequence is done and writes are accepted.
REQ-012 SHALL have port wr_conflict  output  1  registered flag: both write ports targeted the same storable address last cycle.

Function
REQ-013 SHALL store NREGS-1 registers (addresses 0..NREGS-2); no storage for the PC alias.
REQ-014 SHALL implement a two-state FSM: CLEAR, RUN.
REQ-015 In CLEAR, SHALL write zero to register clr_cnt each cycle, clr_cnt counting 0..NREGS-2, ready=0.
REQ-016 SHALL transition CLEAR->RUN on the cycle clr_cnt==NREGS-2 is written; ready=1 from the next cycle; clear takes exactly NREGS-1 cycles after reset deasserts.
REQ-017 In CLEAR, SHALL ignore we0/we1 entirely (no write, no bypass, wr_conflict stays 0).
REQ-018 In CLEAR, rd0..rd2 SHALL read 0 for storable addresses and pc_in for the PC alias.
REQ-019 In RUN, SHALL write wdN to register waN on the rising edge when weN=1 and waN!=NREGS-1.
REQ-020 Writes with waN==NREGS-1 SHALL be discarded silently.
REQ-021 When we0=we1=1 and wa0==wa1 (storable), port 1 SHALL win; wr_conflict SHALL be 1 the following cycle, else 0.
REQ-022 Reads SHALL be combinational: raN==NREGS-1 returns pc_in regardless of writes.
REQ-023 In RUN, a read whose address matches an active same-cycle storable write SHALL return that write data (write-through bypass), port 1 priority over port 0.
REQ-024 Otherwise reads SHALL return stored contents.
REQ-025 All three read ports SHALL be independent; identical addresses give identical data.

Reset
REQ-026 reset=1 at a rising edge SHALL force state=CLEAR, clr_cnt=0, ready=0, wr_conflict=0.
REQ-027 Reset asserted mid-CLEAR SHALL restart clr_cnt at 0; reset in RUN SHALL re-enter CLEAR and re-zero all registers.
REQ-028 While reset=1, SHALL perform no register writes; clearing starts on the first edge with reset=0.

Verification
REQ-029 Reset 1 cycle, release -> ready=0 for 15 cycles, ready=1 on cycle 16; reads of r0..r14 = 0; ra=15 returns pc_in=0x0000_0108.
REQ-030 RUN: we0=1, wa0=3, wd0=0xDEAD_BEEF, ra1=3 same cycle -> rd1=0xDEAD_BEEF combinationally and after edge.
REQ-031 RUN: we0=we1=1, wa0=wa1=5, wd0=0x11, wd1=0x22 -> r5=0x22, rd=0x22 bypass, wr_conflict=1 next cycle then 0.
REQ-032 RUN: we1=1, wa1=15, wd1=0x55 -> no storage changed, ra0=15 returns pc_in, wr_conflict=0.
REQ-033 During CLEAR cycle 4: we0=1, wa0=2, wd0=0x77 -> ignored; r2=0 after ready.
REQ-034 Reset pulsed at CLEAR cycle 7, and again in RUN after r9=0xABCD -> ready rises 15 cycles after each release; r9 reads 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported register file: two write ports, three combinational read ports with write-through
// bypass, a read-only PC alias at the top address, and a post-reset sequential clear.
module regfile_mp #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [WIDTH-1:0]  wd0,
  input  logic [WIDTH-1:0]  wd1,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [WIDTH-1:0]  pc_in,
  output logic [WIDTH-1:0]  rd0,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              ready,
  output logic              wr_conflict
);

  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PcAddr   = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NREGS - 2);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic [WIDTH-1:0]  mem_q [NREGS-1];
  logic              run, wen0, wen1;

  assign run  = (state_q == StRun);
  assign wen0 = run && we0 && (wa0 != PcAddr);
  assign wen1 = run && we1 && (wa1 != PcAddr);

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    wr_conflict_d = wen0 && wen1 && (wa0 == wa1);
    if (state_q == StClear) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == LastAddr) begin
        state_d   = StRun;
        clr_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StClear;
      clr_cnt_q     <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StClear) begin
        mem_q[clr_cnt_q] <= '0;
      end else begin
        if (wen0) mem_q[wa0] <= wd0;
        if (wen1) mem_q[wa1] <= wd1;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    data = '0;
    if (addr == PcAddr) begin
      data = pc_in;
    end else if (run) begin
      if (wen1 && (wa1 == addr)) begin
        data = wd1;
      end else if (wen0 && (wa0 == addr)) begin
        data = wd0;
      end else begin
        data = mem_q[addr];
      end
    end
    return data;
  endfunction

  always_comb begin
    rd0 = read_port(ra0);
    rd1 = read_port(ra1);
    rd2 = read_port(ra2);
  end

  assign ready       = run;
  assign wr_conflict = wr_conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic checked against
// an abstract model (array of register values and a clear countdown).
module tb_regfile_mp;

  localparam int NR = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1;
  logic [3:0]  wa0, wa1, ra0, ra1, ra2;
  logic [31:0] wd0, wd1, pc_in;
  logic [31:0] rd0, rd1, rd2;
  logic        ready, wr_conflict;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_mem [NR-1];
  int          m_clear_left;
  logic        m_conflict;

  regfile_mp #(.WIDTH(32), .ADDR_W(4)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra0(ra0), .ra1(ra1), .ra2(ra2), .pc_in(pc_in),
    .rd0(rd0), .rd1(rd1), .rd2(rd2), .ready(ready), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  // Model: reset makes every register read back as zero and demands 15 clearing cycles before
  // RUN; writes are only honoured in RUN, the PC alias is never stored, port 1 wins.
  function automatic void model_edge();
    if (reset) begin
      for (int i = 0; i < NR - 1; i++) m_mem[i] = '0;
      m_clear_left = NR - 1;
      m_conflict   = 1'b0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
      m_conflict = 1'b0;
    end else begin
      m_conflict = we0 && we1 && (wa0 == wa1) && (wa0 != 4'(NR - 1));
      if (we0 && wa0 != 4'(NR - 1)) m_mem[wa0] = wd0;
      if (we1 && wa1 != 4'(NR - 1)) m_mem[wa1] = wd1;
    end
  endfunction

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    if (a == 4'(NR - 1)) return pc_in;
    if (m_clear_left > 0) return 32'h0;
    if (we1 && wa1 == a && wa1 != 4'(NR - 1)) return wd1;
    if (we0 && wa0 == a && wa0 != 4'(NR - 1)) return wd0;
    return m_mem[a];
  endfunction

  function automatic logic model_ready();
    return m_clear_left == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0;
  endtask

  task automatic test_reset();
    idle();
    ra0 = 0; ra1 = 7; ra2 = 15; pc_in = 32'h0000_0108;
    reset = 1;
    tick();
    reset = 0;
    n_cmp++;
    if (ready !== 1'b0 || wr_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: ready=%b wr_conflict=%b required 0 0", ready, wr_conflict);
    end
    for (int i = 0; i < 15; i++) begin
      n_cmp++;
      if (ready !== 1'b0) begin
        n_err++;
        $display("FAIL clear_ready cycle %0d: got %b required 0", i + 1, ready);
      end
      tick();
    end
    n_cmp++;
    if (ready !== 1'b1 || model_ready() !== 1'b1) begin
      n_err++;
      $display("FAIL ready_cycle16: got %b required 1", ready);
    end
    for (int a = 0; a < 15; a++) begin
      ra0 = 4'(a);
      #1;
      n_cmp++;
      if (rd0 !== 32'h0) begin
        n_err++;
        $display("FAIL cleared_r%0d: got %h required 0", a, rd0);
      end
    end
    ra0 = 15;
    #1;
    n_cmp++;
    if (rd0 !== 32'h0000_0108) begin
      n_err++;
      $display("FAIL pc_alias: got %h required 00000108", rd0);
    end
  endtask

  task automatic test_bypass();
    idle();
    we0 = 1; wa0 = 3; wd0 = 32'hDEAD_BEEF; ra1 = 3;
    #1;
    n_cmp++;
    if (rd1 !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL bypass_comb: got %h required deadbeef", rd1);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd1 !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL bypass_stored: got %h required deadbeef", rd1);
    end
  endtask

  task automatic test_conflict();
    idle();
    we0 = 1; we1 = 1; wa0 = 5; wa1 = 5; wd0 = 32'h11; wd1 = 32'h22; ra2 = 5;
    #1;
    n_cmp++;
    if (rd2 !== 32'h22) begin
      n_err++;
      $display("FAIL conflict_bypass: got %h required 00000022", rd2);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (wr_conflict !== 1'b1 || rd2 !== 32'h22) begin
      n_err++;
      $display("FAIL conflict_flag: wr_conflict=%b r5=%h required 1 00000022", wr_conflict, rd2);
    end
    tick();
    n_cmp++;
    if (wr_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL conflict_clear: got %b required 0", wr_conflict);
    end
  endtask

  task automatic test_pc_write();
    idle();
    we1 = 1; wa1 = 15; wd1 = 32'h55; ra0 = 15; pc_in = 32'h0000_0200;
    #1;
    n_cmp++;
    if (rd0 !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL pc_write_read: got %h required 00000200", rd0);
    end
    tick();
    idle();
    for (int a = 0; a < 15; a++) begin
      ra0 = 4'(a);
      #1;
      n_cmp++;
      if (rd0 !== model_rd(4'(a))) begin
        n_err++;
        $display("FAIL pc_write_storage r%0d: got %h required %h", a, rd0, model_rd(4'(a)));
      end
    end
    n_cmp++;
    if (wr_conflict !== 1'b0) begin
      n_err++;
      $display("FAIL pc_write_conflict: got %b required 0", wr_conflict);
    end
  endtask

  task automatic test_clear_ignore();
    int cnt;
    idle();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) begin
        we0 = 1; wa0 = 2; wd0 = 32'h77; we1 = 1; wa1 = 2; wd1 = 32'h78; ra0 = 2;
        #1;
        n_cmp++;
        if (rd0 !== 32'h0) begin
          n_err++;
          $display("FAIL clear_no_bypass: got %h required 0", rd0);
        end
      end
      tick();
      idle();
      if (i == 4) begin
        n_cmp++;
        if (wr_conflict !== 1'b0) begin
          n_err++;
          $display("FAIL clear_conflict: got %b required 0", wr_conflict);
        end
      end
    end
    ra0 = 2;
    #1;
    n_cmp++;
    if (ready !== 1'b1 || rd0 !== 32'h0) begin
      n_err++;
      $display("FAIL clear_ignore_r2: ready=%b r2=%h required 1 0", ready, rd0);
    end
  endtask

  // Returns the number of cycles from reset release until ready, or -1 if it never rose.
  task automatic release_and_count(output int cycles);
    reset = 0;
    cycles = -1;
    for (int i = 0; i < 40; i++) begin
      if (ready === 1'b1) begin
        cycles = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset_restart();
    int cyc;
    idle();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1;
    tick();
    release_and_count(cyc);
    n_cmp++;
    if (cyc != 15) begin
      n_err++;
      $display("FAIL midclear_restart: ready after %0d cycles required 15", cyc);
    end
    we0 = 1; wa0 = 9; wd0 = 32'hABCD;
    tick();
    idle();
    ra1 = 9;
    #1;
    n_cmp++;
    if (rd1 !== 32'hABCD) begin
      n_err++;
      $display("FAIL r9_written: got %h required 0000abcd", rd1);
    end
    reset = 1;
    tick();
    release_and_count(cyc);
    n_cmp++;
    if (cyc != 15 || rd1 !== 32'h0) begin
      n_err++;
      $display("FAIL run_reset: ready after %0d cycles r9=%h required 15 0", cyc, rd1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
      wa0 = 4'($urandom); wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 4'($urandom);
      wd0 = $urandom; wd1 = $urandom; pc_in = $urandom;
      ra0 = 4'($urandom); ra1 = 4'($urandom); ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 4'($urandom);
      #1;
      n_cmp++;
      if (rd0 !== model_rd(ra0) || rd1 !== model_rd(ra1) || rd2 !== model_rd(ra2)) begin
        n_err++;
        $display("FAIL rand_read c%0d: rd=%h %h %h required %h %h %h", c, rd0, rd1, rd2,
                 model_rd(ra0), model_rd(ra1), model_rd(ra2));
      end
      n_cmp++;
      if (ready !== model_ready() || wr_conflict !== m_conflict) begin
        n_err++;
        $display("FAIL rand_flags c%0d: ready=%b conflict=%b required %b %b", c, ready,
                 wr_conflict, model_ready(), m_conflict);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1;
    idle();
    ra0 = 0; ra1 = 0; ra2 = 0; pc_in = 0;
    test_reset();
    test_bypass();
    test_conflict();
    test_pc_write();
    test_clear_ignore();
    test_reset_restart();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
